// File: rtl/duty_ramp.sv
// duty_ramp: slew-rate limited duty/direction controller for a PWM stage.
//
// A signed duty command sets a target magnitude (saturated to DUTY_MAX) and a
// direction. Once per ramp tick the output duty moves toward the target by at
// most STEP. A direction change is never applied at speed: the duty is first
// ramped to zero, held there for DIR_HOLD ticks, and only then is dir flipped
// and the ramp continues in the new direction.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   reset      in   asynchronous, active-high reset
//   enable     in   1: track the stored target; 0: ramp toward zero
//   cmd_valid  in   command present on cmd_duty
//   cmd_ready  out  command can be accepted this cycle (low while holding)
//   cmd_duty   in   signed duty command, sign selects direction
//   duty       out  unsigned duty magnitude, never above DUTY_MAX
//   dir        out  0 = forward, 1 = reverse
//   at_target  out  duty/dir have settled on the effective target
module duty_ramp #(
    parameter int CLK_FREQ = 32_000_000,
    parameter int PWM_FREQ = 20_000,
    parameter int STEP     = 16,
    parameter int RAMP_DIV = 1600,
    parameter int DIR_HOLD = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic signed [24:0] cmd_duty,
    output logic [23:0]        duty,
    output logic               dir,
    output logic               at_target
);

    localparam int DATA_W   = 24;
    localparam int DUTY_MAX = CLK_FREQ / PWM_FREQ;
    localparam logic [DATA_W-1:0] DUTY_MAX_V = DATA_W'(DUTY_MAX);
    localparam logic [DATA_W-1:0] STEP_V     = DATA_W'(STEP);

    localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

    // DIR_HOLD is expected to be at least 1.
    localparam int HOLD_W = (DIR_HOLD > 1) ? $clog2(DIR_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DIR_HOLD - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [PRE_W-1:0]  r_pre;
    logic [1:0]        r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [DATA_W-1:0] r_duty;
    logic              r_dir;
    logic              r_at;
    logic [DATA_W-1:0] r_tgt_mag;
    logic              r_tgt_dir;

    logic              w_tick;
    logic              w_accept;
    logic [DATA_W-1:0] w_eff_mag;
    logic              w_eff_dir;
    logic [DATA_W-1:0] w_duty_nx;
    logic              w_dir_nx;
    logic [1:0]        w_state_nx;
    logic [HOLD_W-1:0] w_hold_nx;

    // |v| saturated to DUTY_MAX. Done in 25 bits so that -2^24 yields 2^24
    // rather than wrapping, and then clamps like any other large command.
    function automatic logic [DATA_W-1:0] sat_mag(input logic signed [24:0] v);
        logic [24:0] mag;
        mag = v[24] ? $unsigned(-v) : $unsigned(v);
        if (mag > {1'b0, DUTY_MAX_V}) begin
            return DUTY_MAX_V;
        end
        return mag[DATA_W-1:0];
    endfunction

    // One ramp step toward tgt; the last step is the remaining difference.
    function automatic logic [DATA_W-1:0] step_toward(input logic [DATA_W-1:0] cur,
                                                      input logic [DATA_W-1:0] tgt);
        logic [DATA_W-1:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            return (diff > STEP_V) ? cur + STEP_V : tgt;
        end
        diff = cur - tgt;
        return (diff > STEP_V) ? cur - STEP_V : tgt;
    endfunction

    assign w_tick    = (r_pre == PRE_LAST);
    assign cmd_ready = (r_state != S_HOLD);
    assign w_accept  = cmd_valid && cmd_ready;

    // A zero-magnitude target has no direction of its own; it follows the
    // current dir so that ramping to zero never triggers a reversal.
    assign w_eff_mag = enable ? r_tgt_mag : '0;
    assign w_eff_dir = (w_eff_mag == '0) ? r_dir : r_tgt_dir;

    // IDLE and RAMP share one tick rule: step once, then the state is IDLE
    // exactly when the step landed on the target. A settled IDLE tick is a
    // no-op, and a mismatch found in IDLE starts ramping on that tick.
    always_comb begin
        w_duty_nx  = r_duty;
        w_dir_nx   = r_dir;
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        if (w_tick) begin
            case (r_state)
                S_IDLE, S_RAMP: begin
                    if (w_eff_dir != r_dir) begin
                        w_duty_nx  = (r_duty > STEP_V) ? r_duty - STEP_V : '0;
                        w_state_nx = (w_duty_nx == '0) ? S_HOLD : S_RAMP;
                        w_hold_nx  = '0;
                    end else begin
                        w_duty_nx  = step_toward(r_duty, w_eff_mag);
                        w_state_nx = (w_duty_nx == w_eff_mag) ? S_IDLE : S_RAMP;
                    end
                end
                S_HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        w_dir_nx   = ~r_dir;
                        w_hold_nx  = '0;
                        w_state_nx = (w_eff_mag == '0) ? S_IDLE : S_RAMP;
                    end else begin
                        w_hold_nx  = r_hold + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre     <= '0;
            r_state   <= S_IDLE;
            r_hold    <= '0;
            r_duty    <= '0;
            r_dir     <= 1'b0;
            r_at      <= 1'b1;
            r_tgt_mag <= '0;
            r_tgt_dir <= 1'b0;
        end else begin
            // Free-running prescaler; commands never restart it.
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            r_state <= w_state_nx;
            r_hold  <= w_hold_nx;
            r_duty  <= w_duty_nx;
            r_dir   <= w_dir_nx;
            r_at    <= (w_state_nx == S_IDLE);
            // A command landing on a tick edge is stored after that tick has
            // already used the old target.
            if (w_accept) begin
                r_tgt_mag <= sat_mag(cmd_duty);
                r_tgt_dir <= cmd_duty[24];
            end
        end
    end

    assign duty      = r_duty;
    assign dir       = r_dir;
    assign at_target = r_at;

endmodule

// File: doc/duty_ramp.md
DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 Parameter CLK_FREQ, default 32_000_000, system clock frequency in Hz.
REQ-002 Parameter PWM_FREQ, default 20_000, PWM frequency in Hz; DUTY_MAX = CLK_FREQ/PWM_FREQ (1600 at defaults).
REQ-003 Parameter STEP, default 16, maximum duty change per ramp tick.
REQ-004 Parameter RAMP_DIV, default 1600, clk cycles per ramp tick.
REQ-005 Parameter DIR_HOLD, default 2, ramp ticks held at zero duty before a direction flip.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  high: track commanded target; low: effective target magnitude 0.
REQ-009 cmd_valid  input  1  command present.
REQ-010 cmd_ready  output  1  command can be accepted this cycle.
REQ-011 cmd_duty  input  25  signed two's-complement duty command; sign selects direction.
REQ-012 duty  output  24  unsigned duty magnitude for the downstream PWM generator.
REQ-013 dir  output  1  0 = forward (non-negative), 1 = reverse.
REQ-014 at_target  output  1  high when duty and dir equal the effective target.

Function
REQ-015 Command SHALL be accepted on a rising edge with cmd_valid && cmd_ready; the accepted value replaces the stored target; unaccepted commands SHALL be ignored.
REQ-016 Stored target magnitude SHALL be |cmd_duty| saturated to DUTY_MAX; target dir = sign bit; -2^24 SHALL saturate to DUTY_MAX reverse.
REQ-017 Target magnitude 0 SHALL be treated as matching the current dir (no reversal).
REQ-018 Prescaler SHALL count 0..RAMP_DIV-1 continuously; ramp tick = one cycle when count == RAMP_DIV-1, then wrap to 0.
REQ-019 States: IDLE, RAMP, HOLD; cmd_ready SHALL be 1 in IDLE and RAMP, 0 in HOLD.
REQ-020 IDLE -> RAMP when the effective target differs from (duty, dir); evaluation takes effect on the next tick.
REQ-021 RAMP, same dir: each tick duty moves toward target magnitude by STEP, never overshooting (final step = remaining difference).
REQ-022 RAMP, opposite dir: each tick duty decreases by min(STEP, duty); on reaching 0 -> HOLD.
REQ-023 HOLD: duty held 0 for DIR_HOLD ticks; on the last hold tick dir toggles and state -> RAMP (or IDLE if target magnitude 0).
REQ-024 RAMP -> IDLE when duty and dir equal the effective target after a tick.
REQ-025 Command accepted on the same edge as a tick: that tick SHALL use the previously stored target; the new target applies from the next tick.
REQ-026 New command mid-RAMP SHALL redirect the ramp from the current duty without reset of the prescaler.
REQ-027 enable deasserted: ramp toward 0 at STEP/tick, dir unchanged; stored target retained and resumed when enable returns.
REQ-028 duty, dir, at_target SHALL be registered; duty SHALL never exceed DUTY_MAX.
REQ-029 at_target SHALL equal (state == IDLE).

Reset
REQ-030 On reset: duty 0, dir 0, target 0 forward, prescaler 0, hold count 0, state IDLE, at_target 1, cmd_ready 1; asserted immediately, independent of clk.
REQ-031 Reset mid-ramp or mid-HOLD SHALL abandon the operation; first tick after release occurs RAMP_DIV cycles later.

Verification (bench parameters RAMP_DIV=4, STEP=16, DIR_HOLD=2, defaults otherwise)
REQ-032 Assert reset mid-simulation with no clk edge -> duty 0, dir 0, at_target 1, cmd_ready 1 immediately.
REQ-033 Command +100 from 0 -> duty 16,32,48,64,80,96,100 on seven successive ticks, then at_target 1, IDLE.
REQ-034 Command +5000 -> duty saturates and holds at 1600; command -16777216 from 0 -> dir 1 after hold, duty ramps to 1600.
REQ-035 At duty 48 dir 0, command -32 -> duty 32,16,0; HOLD 2 ticks with cmd_ready 0; dir 1; duty 16,32; at_target 1.
REQ-036 At duty 100 dir 0, enable low -> duty 84,68,...,4,0, dir stays 0; enable high -> ramps back to 100.
REQ-037 Command accepted on a tick edge -> that tick steps toward the old target, next tick toward the new one; reset during HOLD -> IDLE, duty 0, dir 0.
